// File: rtl/fifo_rd_feeder_pkg.sv
// Shared definitions for the FIFO read-side feeder: FSM state encoding and
// the lane-counter width helper.
package fifo_rd_feeder_pkg;

  typedef logic [1:0] feed_state_t;

  localparam feed_state_t ST_IDLE = 2'b00;
  localparam feed_state_t ST_POP  = 2'b01;
  localparam feed_state_t ST_SEND = 2'b10;
  localparam feed_state_t ST_WAIT = 2'b11;

  // Ceiling log2, never below 1, so a single-lane build still gets a legal counter.
  function automatic int clog2_min1(input int value);
    int width;
    width = 32'sd1;
    while ((32'sd1 <<< width) < value) begin
      width = width + 32'sd1;
    end
    return width;
  endfunction

endpackage

// File: rtl/fifo_rd_feeder_if.sv
// Feeder-side bundle: FIFO read port plus the transmitter valid/busy handshake.
interface fifo_rd_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 8
);

  logic                  en;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  r_inc;
  logic [OUT_WIDTH-1:0]  tx_p_data;
  logic                  tx_data_valid;
  logic                  busy;
  logic                  feed_active;

  modport master (
    input  en,
    input  empty,
    input  rd_data,
    input  busy,
    output r_inc,
    output tx_p_data,
    output tx_data_valid,
    output feed_active
  );

  modport slave (
    output en,
    output empty,
    output rd_data,
    output busy,
    input  r_inc,
    input  tx_p_data,
    input  tx_data_valid,
    input  feed_active
  );

endinterface

// File: rtl/fifo_lane_sel.sv
// Holds the popped word and walks its OUT_WIDTH lanes, LSB lane first.
module fifo_lane_sel
  import fifo_rd_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] load_word,
  output logic [OUT_WIDTH-1:0]  lane_data,
  output logic                  last_lane
);

  localparam int LANES      = DATA_WIDTH / OUT_WIDTH;
  localparam int LANE_CNT_W = clog2_min1(LANES);

  logic [DATA_WIDTH-1:0] word_r;
  logic [LANE_CNT_W-1:0] lane_cnt_r;

  assign last_lane = (lane_cnt_r == LANE_CNT_W'(LANES - 1));

  // Word register: captured only on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= '0;
    end else if (load) begin
      word_r <= load_word;
    end else begin
      word_r <= word_r;
    end
  end

  // Lane counter: cleared by a pop and never allowed past the last lane, so a
  // single-lane build folds to a constant zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_r <= '0;
    end else if (load) begin
      lane_cnt_r <= '0;
    end else if (advance && !last_lane) begin
      lane_cnt_r <= lane_cnt_r + LANE_CNT_W'(1);
    end else begin
      lane_cnt_r <= lane_cnt_r;
    end
  end

  generate
    if (LANES > 1) begin : g_multi_lane
      logic [OUT_WIDTH-1:0] lanes_s [LANES];
      for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lanes_s[g] = word_r[g*OUT_WIDTH +: OUT_WIDTH];
      end
      assign lane_data = lanes_s[lane_cnt_r];
    end else begin : g_single_lane
      assign lane_data = word_r[OUT_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/fifo_rd_feeder.sv
// Read-domain drain controller: pops one FIFO word at a time and hands its
// lanes to a parallel-load serial transmitter over a valid/busy handshake.
module fifo_rd_feeder
  import fifo_rd_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_rd_feeder_if.master  bus
);

  feed_state_t          state_r;
  feed_state_t          next_state_s;
  logic                 load_s;
  logic                 advance_s;
  logic                 last_lane_s;
  logic [OUT_WIDTH-1:0] lane_data_s;

  assign load_s    = (state_r == ST_POP);
  assign advance_s = (state_r == ST_WAIT) && !bus.busy;

  fifo_lane_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_lane_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .advance   (advance_s),
    .load_word (bus.rd_data),
    .lane_data (lane_data_s),
    .last_lane (last_lane_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; EN only gates the start of a new word, and a busy
  // transmitter seen on SEND entry is taken as acceptance.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.en && !bus.empty) begin
          next_state_s = ST_POP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_POP: begin
        next_state_s = ST_SEND;
      end
      ST_SEND: begin
        if (bus.busy) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (bus.busy) begin
          next_state_s = ST_WAIT;
        end else if (last_lane_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_SEND;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Outputs decode the state register and the word/lane registers only.
  assign bus.r_inc         = (state_r == ST_POP);
  assign bus.tx_data_valid = (state_r == ST_SEND);
  assign bus.feed_active   = (state_r != ST_IDLE);
  assign bus.tx_p_data     = lane_data_s;

endmodule

// File: tb/tb_fifo_rd_feeder.sv
// Directed bench for fifo_rd_feeder: FIFO and transmitter models around a
// 16/8 instance, plus a hand-driven 8/8 single-lane instance.
module tb_fifo_rd_feeder;

  localparam int FRAME = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_feeder_if #(.DATA_WIDTH(16), .OUT_WIDTH(8)) bus ();
  fifo_rd_feeder_if #(.DATA_WIDTH(8),  .OUT_WIDTH(8)) bus8 ();

  fifo_rd_feeder #(.DATA_WIDTH(16), .OUT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fifo_rd_feeder #(.DATA_WIDTH(8), .OUT_WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int total = 0;
  int bad   = 0;

  // FIFO model: pointer moves on the popping edge, data and empty follow it.
  logic [15:0] fifo_mem [8];
  logic [3:0]  rd_ptr = 4'd0;
  logic [3:0]  wr_cnt = 4'd0;
  int          pop_cnt = 0;
  int          pop_cyc [8];
  int          cyc = 0;
  int          pop8 = 0;

  assign bus.rd_data = fifo_mem[rd_ptr[2:0]];
  assign bus.empty   = (rd_ptr == wr_cnt);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.r_inc) begin
      rd_ptr  <= rd_ptr + 4'd1;
      pop_cnt <= pop_cnt + 1;
      if (pop_cnt < 8) pop_cyc[pop_cnt] <= cyc;
    end
    if (bus8.r_inc) pop8 <= pop8 + 1;
  end

  // Transmitter model: accepts after accept_dly valid cycles, busy for FRAME cycles.
  int          accept_dly = 0;
  int          dly_cnt = 0;
  int          frame_cnt = 0;
  logic [7:0]  lane_log [16];
  int          lane_n = 0;
  logic        valid_q = 1'b0;
  int          foreign = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy  <= 1'b0;
      dly_cnt   <= 0;
      frame_cnt <= 0;
    end else if (!bus.busy) begin
      if (bus.tx_data_valid) begin
        if (dly_cnt >= accept_dly) begin
          bus.busy  <= 1'b1;
          frame_cnt <= FRAME - 1;
          dly_cnt   <= 0;
          if (lane_n < 16) lane_log[lane_n] <= bus.tx_p_data;
          lane_n <= lane_n + 1;
        end else begin
          dly_cnt <= dly_cnt + 1;
        end
      end else begin
        dly_cnt <= 0;
      end
    end else if (frame_cnt == 0) begin
      bus.busy <= 1'b0;
    end else begin
      frame_cnt <= frame_cnt - 1;
    end
  end

  always @(posedge clk) begin
    valid_q <= bus.tx_data_valid;
    if (bus.tx_data_valid && !valid_q && bus.busy) foreign <= foreign + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.tx_data_valid && n < 20) begin
      @(negedge clk);
      n = n + 1;
    end
    check_val(tag, 32'(bus.tx_data_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.feed_active && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    check_val(tag, 32'(bus.feed_active), 32'd0);
  endtask

  initial begin
    int n;
    int gap;
    for (int i = 0; i < 8; i++) fifo_mem[i] = 16'h0000;
    bus.en       = 1'b0;
    bus8.en      = 1'b0;
    bus8.empty   = 1'b1;
    bus8.rd_data = 8'hC3;
    bus8.busy    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_r_inc", 32'(bus.r_inc), 32'd0);
    check_val("rst_valid", 32'(bus.tx_data_valid), 32'd0);
    check_val("rst_active", 32'(bus.feed_active), 32'd0);
    check_val("rst_data", 32'(bus.tx_p_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-lane instance
    bus8.en = 1'b1;
    bus8.empty = 1'b0;
    @(negedge clk);
    check_val("w8_r_inc", 32'(bus8.r_inc), 32'd1);
    bus8.empty = 1'b1;
    @(negedge clk);
    check_val("w8_valid", 32'(bus8.tx_data_valid), 32'd1);
    check_val("w8_data", 32'(bus8.tx_p_data), 32'hC3);
    bus8.busy = 1'b1;
    @(negedge clk);
    check_val("w8_valid_drop", 32'(bus8.tx_data_valid), 32'd0);
    bus8.busy = 1'b0;
    @(negedge clk);
    check_val("w8_idle", 32'(bus8.feed_active), 32'd0);
    repeat (5) @(negedge clk);
    check_val("w8_pops", 32'(pop8), 32'd1);

    // Single word, latency and lane order
    fifo_mem[0] = 16'hA55A;
    bus.en = 1'b1;
    wr_cnt = 4'd1;
    @(negedge clk);
    check_val("sw_r_inc_c1", 32'(bus.r_inc), 32'd1);
    check_val("sw_valid_c1", 32'(bus.tx_data_valid), 32'd0);
    @(negedge clk);
    check_val("sw_r_inc_c2", 32'(bus.r_inc), 32'd0);
    check_val("sw_valid_c2", 32'(bus.tx_data_valid), 32'd1);
    check_val("sw_lane0", 32'(bus.tx_p_data), 32'h5A);
    n = 0;
    while (!(bus.tx_data_valid && bus.tx_p_data == 8'hA5) && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    check_val("sw_lane1", {23'd0, bus.tx_data_valid, bus.tx_p_data}, 32'h1A5);
    wait_idle("sw_idle_timeout");
    repeat (10) @(negedge clk);
    check_val("sw_pops", 32'(pop_cnt), 32'd1);
    check_val("sw_log0", 32'(lane_log[0]), 32'h5A);
    check_val("sw_log1", 32'(lane_log[1]), 32'hA5);

    // Back-to-back words
    fifo_mem[1] = 16'h1234;
    fifo_mem[2] = 16'hBEEF;
    wr_cnt = 4'd3;
    n = 0;
    while (!(pop_cnt == 3 && !bus.feed_active) && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    check_val("b2b_pops", 32'(pop_cnt), 32'd3);
    check_val("b2b_l0", 32'(lane_log[2]), 32'h34);
    check_val("b2b_l1", 32'(lane_log[3]), 32'h12);
    check_val("b2b_l2", 32'(lane_log[4]), 32'hEF);
    check_val("b2b_l3", 32'(lane_log[5]), 32'hBE);
    gap = pop_cyc[2] - pop_cyc[1];
    check_val("b2b_gap", 32'((gap >= 2 * FRAME) && (gap > 1)), 32'd1);

    // Handshake hold while the transmitter stalls acceptance
    accept_dly = 6;
    fifo_mem[3] = 16'h7788;
    wr_cnt = 4'd4;
    wait_valid("hold_start");
    for (int i = 0; i < 7; i++) begin
      check_val("hold_stable", {22'd0, bus.busy, bus.tx_data_valid, bus.tx_p_data}, 32'h188);
      @(negedge clk);
    end
    check_val("hold_busy_seen", 32'(bus.busy), 32'd1);
    check_val("hold_valid_kept", 32'(bus.tx_data_valid), 32'd1);
    @(negedge clk);
    check_val("hold_valid_drop", 32'(bus.tx_data_valid), 32'd0);
    wait_idle("hold_idle_timeout");
    accept_dly = 0;
    check_val("hold_log0", 32'(lane_log[6]), 32'h88);
    check_val("hold_log1", 32'(lane_log[7]), 32'h77);

    // Enable gating
    bus.en = 1'b0;
    fifo_mem[4] = 16'hCAFE;
    fifo_mem[5] = 16'h0F0F;
    wr_cnt = 4'd6;
    repeat (10) @(negedge clk);
    check_val("en_off_pops", 32'(pop_cnt), 32'd4);
    check_val("en_off_active", 32'(bus.feed_active), 32'd0);
    bus.en = 1'b1;
    wait_valid("en_lane0");
    bus.en = 1'b0;
    wait_idle("en_idle_timeout");
    repeat (10) @(negedge clk);
    check_val("en_mid_pops", 32'(pop_cnt), 32'd5);
    check_val("en_mid_l0", 32'(lane_log[8]), 32'hFE);
    check_val("en_mid_l1", 32'(lane_log[9]), 32'hCA);
    check_val("en_mid_empty", 32'(bus.empty), 32'd0);

    // Asynchronous reset in the middle of SEND
    accept_dly = 1000;
    bus.en = 1'b1;
    wait_valid("rs_in_send");
    rst_n = 1'b0;
    #1;
    check_val("rs_valid", 32'(bus.tx_data_valid), 32'd0);
    check_val("rs_r_inc", 32'(bus.r_inc), 32'd0);
    check_val("rs_active", 32'(bus.feed_active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    accept_dly = 0;
    repeat (20) @(negedge clk);
    check_val("rs_pops", 32'(pop_cnt), 32'd6);
    check_val("rs_idle", 32'(bus.feed_active), 32'd0);
    check_val("rs_lanes", 32'(lane_n), 32'd10);
    check_val("busy_on_entry", 32'(foreign), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
